// File: rtl/sprite_blitter_pkg.sv
// Shared constants, types and helpers for the sprite blitter.
// Screen geometry, sprite geometry, colour codes and the blitter FSM states.
package sprite_pkg;
    localparam int SPRITE_W    = 24;
    localparam int SPRITE_H    = 45;
    localparam int NUM_SPRITES = 16;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int IDX_W       = $clog2(NUM_SPRITES);
    localparam int ROM_AW      = 15;
    localparam int FB_AW       = 19;
    localparam int COORD_W     = 12;

    typedef logic [4:0] pixel_t;
    localparam pixel_t TRANSPARENT = 5'h15;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} blit_state_t;

    // Screen coordinates travelling alongside a ROM read.
    typedef struct packed {
        logic [COORD_W-1:0] sx;
        logic [COORD_W-1:0] sy;
        logic               on;
    } coord_t;

    // Only ever called with non-negative, on-screen coordinates.
    function automatic logic [FB_AW-1:0] fb_addr(logic [COORD_W-1:0] x, logic [COORD_W-1:0] y);
        return FB_AW'(y) * FB_AW'(SCREEN_W) + FB_AW'(x);
    endfunction
endpackage

// File: rtl/sprite_blitter_if.sv
// Request, sprite-ROM and frame-buffer write signals of the blitter.
// master = game logic / memories side, slave = blitter.
interface sprite_blitter_if;
    import sprite_pkg::*;

    logic               Start;
    logic [10:0]        SpriteX;
    logic [10:0]        SpriteY;
    logic [IDX_W-1:0]   SpriteIdx;
    logic               FlipX;
    logic [ROM_AW-1:0]  RomAddr;
    pixel_t             RomData;
    logic               FbWe;
    logic [FB_AW-1:0]   FbAddr;
    pixel_t             FbData;
    logic               Busy;
    logic               Done;

    modport master (
        output Start, SpriteX, SpriteY, SpriteIdx, FlipX, RomData,
        input  RomAddr, FbWe, FbAddr, FbData, Busy, Done
    );
    modport slave (
        input  Start, SpriteX, SpriteY, SpriteIdx, FlipX, RomData,
        output RomAddr, FbWe, FbAddr, FbData, Busy, Done
    );
endinterface

// File: rtl/sprite_blitter_addr_gen.sv
// Texel walker: col/row counters, horizontal flip, ROM address and clipped screen coordinates.
// Parameters are latched on load_i; the walk advances one texel per cycle while step_i is high.
module blit_addr_gen
    import sprite_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                step_i,
    input  logic [10:0]         x_i,
    input  logic [10:0]         y_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic                flip_i,
    output logic [ROM_AW-1:0]   rom_addr_o,
    output coord_t              coord_o,
    output logic                last_o
);
    localparam logic [4:0] COL_MAX = 5'(SPRITE_W - 1);
    localparam logic [5:0] ROW_MAX = 6'(SPRITE_H - 1);

    logic [4:0]       col_q, col_d;
    logic [5:0]       row_q, row_d;
    logic [10:0]      x_q, y_q;
    logic [IDX_W-1:0] idx_q;
    logic             flip_q;
    logic [4:0]       tex_col;
    logic [COORD_W-1:0] sx, sy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            idx_q  <= '0;
            flip_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (load_i) begin
                x_q    <= x_i;
                y_q    <= y_i;
                idx_q  <= idx_i;
                flip_q <= flip_i;
            end
        end
    end

    assign last_o = (row_q == ROW_MAX) && (col_q == COL_MAX);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (load_i) begin
            col_d = '0;
            row_d = '0;
        end else if (step_i) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = last_o ? '0 : row_q + 6'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
        end
    end

    // Flip only changes which texel is fetched; the screen column is always col.
    assign tex_col    = flip_q ? (COL_MAX - col_q) : col_q;
    assign rom_addr_o = ROM_AW'(idx_q) * ROM_AW'(SPRITE_W * SPRITE_H)
                      + ROM_AW'(row_q) * ROM_AW'(SPRITE_W) + ROM_AW'(tex_col);

    // Two's complement sum: sign-extended origin plus zero-extended offset.
    assign sx = {x_q[10], x_q} + {7'd0, col_q};
    assign sy = {y_q[10], y_q} + {6'd0, row_q};

    assign coord_o.sx = sx;
    assign coord_o.sy = sy;
    assign coord_o.on = !sx[COORD_W-1] && (sx < 12'(SCREEN_W))
                     && !sy[COORD_W-1] && (sy < 12'(SCREEN_H));
endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter top: FSM, ROM-read pipeline and frame-buffer write port.
// Pipeline: issue ROM address -> ROM data returns -> registered write strobe.
module sprite_blitter
    import sprite_pkg::*;
(
    input  logic Clk,
    input  logic Reset_n,
    sprite_blitter_if.slave bus
);
    blit_state_t       state_q, state_d;
    logic [1:0]        vld_pipe_q;
    coord_t [1:0]      crd_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic              fb_we_q;
    logic [FB_AW-1:0]  fb_addr_q;
    pixel_t            fb_data_q;

    logic              load, step, last, we_d;
    logic [ROM_AW-1:0] rom_addr;
    coord_t            coord;

    assign load = (state_q == IDLE) && bus.Start;
    assign step = (state_q == RUN);

    blit_addr_gen u_addr_gen (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .load_i     (load),
        .step_i     (step),
        .x_i        (bus.SpriteX),
        .y_i        (bus.SpriteY),
        .idx_i      (bus.SpriteIdx),
        .flip_i     (bus.FlipX),
        .rom_addr_o (rom_addr),
        .coord_o    (coord),
        .last_o     (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Start) state_d = RUN;
            RUN:     if (last) state_d = DRAIN;
            DRAIN:   if (vld_pipe_q == 2'b00) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign we_d = vld_pipe_q[1] && crd_q[1].on && (bus.RomData != TRANSPARENT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            vld_pipe_q <= '0;
            crd_q      <= '0;
            rom_addr_q <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            vld_pipe_q <= {vld_pipe_q[0], step};
            crd_q      <= {crd_q[0], coord};
            if (step) rom_addr_q <= rom_addr;
            fb_we_q <= we_d;
            // Address is only formed for clipped, on-screen texels; otherwise hold.
            if (we_d) begin
                fb_addr_q <= fb_addr(crd_q[1].sx, crd_q[1].sy);
                fb_data_q <= bus.RomData;
            end
        end
    end

    assign bus.RomAddr = rom_addr_q;
    assign bus.FbWe    = fb_we_q;
    assign bus.FbAddr  = fb_addr_q;
    assign bus.FbData  = fb_data_q;
    assign bus.Busy    = (state_q != IDLE);
    assign bus.Done    = (state_q == DONE);
endmodule
